// File: rtl/mem_stage_if.sv
// EXE->MEM->WB pipeline link of the memory stage, including the data-SRAM response path.
// The slave modport is the MEM stage's view; master is the surrounding pipeline.
interface mem_stage_if #(
    parameter int unsigned EXC_W = 119,
    parameter int unsigned TLB_W = 10
);
    logic             exe_valid;
    logic             mem_allowin;
    logic [74:0]      exe_to_mem_bus;
    logic [EXC_W-1:0] exe_excep_bus;
    logic [TLB_W-1:0] exe_tlb_bus;
    logic             data_sram_data_ok;
    logic [31:0]      data_sram_rdata;
    logic             wb_allowin;
    logic             wb_flush;
    logic             mem_to_wb_valid;
    logic [69:0]      mem_to_wb_bus;
    logic [EXC_W-1:0] mem_to_wb_excep;
    logic [TLB_W-1:0] mem_to_wb_tlb;
    logic [38:0]      mem_fwd;
    logic             mem_cancel;

    modport master (
        output exe_valid, exe_to_mem_bus, exe_excep_bus, exe_tlb_bus,
               data_sram_data_ok, data_sram_rdata, wb_allowin, wb_flush,
        input  mem_allowin, mem_to_wb_valid, mem_to_wb_bus, mem_to_wb_excep,
               mem_to_wb_tlb, mem_fwd, mem_cancel
    );

    modport slave (
        input  exe_valid, exe_to_mem_bus, exe_excep_bus, exe_tlb_bus,
               data_sram_data_ok, data_sram_rdata, wb_allowin, wb_flush,
        output mem_allowin, mem_to_wb_valid, mem_to_wb_bus, mem_to_wb_excep,
               mem_to_wb_tlb, mem_fwd, mem_cancel
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, waits for its in-order load response,
// buffers it under WB back-pressure and drops responses orphaned by a flush.
module mem_stage #(
    parameter int unsigned EXC_W = 119,
    parameter int unsigned TLB_W = 10
) (
    input  logic      clk,
    input  logic      resetn,
    mem_stage_if.slave mif
);
    // Exception and ertn flags sit in the two low bits of the excep bus.
    localparam int unsigned EXC_FLAG_BIT  = 0;
    localparam int unsigned ERTN_FLAG_BIT = 1;

    logic             mem_valid_q, mem_valid_d;
    logic             buf_valid_q, buf_valid_d;
    logic             discard_q,   discard_d;
    logic [31:0]      rdata_buf_q, rdata_buf_d;
    logic [74:0]      bus_q,       bus_d;
    logic [EXC_W-1:0] excep_q,     excep_d;
    logic [TLB_W-1:0] tlb_q,       tlb_d;

    logic [31:0] pc, alu_result, load_word, ld_result, final_result;
    logic [4:0]  rf_waddr;
    logic [2:0]  ld_type;
    logic        rf_we, res_from_mem, req_sent;
    logic        data_live, mem_readygo, allowin, accept, leave;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign {pc, rf_we, rf_waddr, alu_result, res_from_mem, ld_type, req_sent} = bus_q;

    assign data_live   = mif.data_sram_data_ok & ~discard_q;
    assign mem_readygo = ~req_sent | buf_valid_q | data_live;
    assign allowin     = ~mem_valid_q | (mem_readygo & mif.wb_allowin);
    assign accept      = mif.exe_valid & allowin;
    assign leave       = mem_valid_q & mem_readygo & mif.wb_allowin;

    always_comb begin
        mem_valid_d = mem_valid_q;
        if (mif.wb_flush)
            mem_valid_d = 1'b0;
        else if (allowin)
            mem_valid_d = mif.exe_valid;

        bus_d   = accept ? mif.exe_to_mem_bus : bus_q;
        excep_d = accept ? mif.exe_excep_bus  : excep_q;
        tlb_d   = accept ? mif.exe_tlb_bus    : tlb_q;

        buf_valid_d = buf_valid_q;
        rdata_buf_d = rdata_buf_q;
        if (mif.wb_flush || leave) begin
            buf_valid_d = 1'b0;
        end else if (mem_valid_q && req_sent && data_live && !buf_valid_q) begin
            buf_valid_d = 1'b1;
            rdata_buf_d = mif.data_sram_rdata;
        end

        // A flush only orphans a response that is still in flight; one landing
        // in the flush cycle itself is simply ignored.
        discard_d = discard_q;
        if (discard_q) begin
            if (mif.data_sram_data_ok)
                discard_d = 1'b0;
        end else if (mif.wb_flush && mem_valid_q && req_sent && !buf_valid_q
                     && !mif.data_sram_data_ok) begin
            discard_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_valid_q <= 1'b0;
            buf_valid_q <= 1'b0;
            discard_q   <= 1'b0;
            rdata_buf_q <= '0;
            bus_q       <= '0;
            excep_q     <= '0;
            tlb_q       <= '0;
        end else begin
            mem_valid_q <= mem_valid_d;
            buf_valid_q <= buf_valid_d;
            discard_q   <= discard_d;
            rdata_buf_q <= rdata_buf_d;
            bus_q       <= bus_d;
            excep_q     <= excep_d;
            tlb_q       <= tlb_d;
        end
    end

    assign load_word = buf_valid_q ? rdata_buf_q : mif.data_sram_rdata;

    always_comb begin
        case (alu_result[1:0])
            2'd0:    ld_byte = load_word[7:0];
            2'd1:    ld_byte = load_word[15:8];
            2'd2:    ld_byte = load_word[23:16];
            default: ld_byte = load_word[31:24];
        endcase
        ld_half = alu_result[1] ? load_word[31:16] : load_word[15:0];
        case (ld_type)
            3'b001:  ld_result = {{24{ld_byte[7]}}, ld_byte};
            3'b010:  ld_result = {{16{ld_half[15]}}, ld_half};
            3'b011:  ld_result = {24'd0, ld_byte};
            3'b100:  ld_result = {16'd0, ld_half};
            default: ld_result = load_word;
        endcase
    end

    assign final_result = res_from_mem ? ld_result : alu_result;

    assign mif.mem_allowin     = allowin;
    assign mif.mem_to_wb_valid = mem_valid_q & mem_readygo & ~mif.wb_flush;
    assign mif.mem_to_wb_bus   = {pc, rf_we, rf_waddr, final_result};
    assign mif.mem_to_wb_excep = excep_q;
    assign mif.mem_to_wb_tlb   = tlb_q;
    assign mif.mem_fwd         = {mem_valid_q & rf_we, rf_waddr, final_result,
                                  mem_valid_q & res_from_mem & ~mem_readygo};
    assign mif.mem_cancel      = mem_valid_q & (excep_q[EXC_FLAG_BIT] | excep_q[ERTN_FLAG_BIT]);
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus a randomized run against a
// transaction-level model of the stage.
module tb_mem_stage;
    localparam int unsigned EXC_W = 119;
    localparam int unsigned TLB_W = 10;

    logic clk = 1'b0;
    logic resetn;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    mem_stage_if #(.EXC_W(EXC_W), .TLB_W(TLB_W)) mif ();
    mem_stage #(.EXC_W(EXC_W), .TLB_W(TLB_W)) dut (.clk(clk), .resetn(resetn), .mif(mif));

    typedef struct {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] alu;
        logic        rfm;
        logic [2:0]  ldt;
        logic        rs;
    } instr_t;

    function automatic logic [74:0] mk_bus(logic [31:0] pc, logic we, logic [4:0] waddr,
                                           logic [31:0] alu, logic rfm, logic [2:0] ldt, logic rs);
        return {pc, we, waddr, alu, rfm, ldt, rs};
    endfunction

    function automatic logic [EXC_W-1:0] rand_exc();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[EXC_W-1:0];
    endfunction

    // Load extraction by shifting and arithmetic sign adjustment.
    function automatic logic [31:0] ref_load(logic [31:0] word, logic [1:0] off, logic [2:0] t);
        logic [31:0] sb, sh;
        sb = word >> (32'(off) * 8);
        sh = word >> (32'(off & 2'd2) * 8);
        case (t)
            3'd1:    return ((sb & 32'hFF) >= 32'd128) ? (sb & 32'hFF) - 32'd256 : (sb & 32'hFF);
            3'd2:    return ((sh & 32'hFFFF) >= 32'd32768) ? (sh & 32'hFFFF) - 32'd65536 : (sh & 32'hFFFF);
            3'd3:    return sb & 32'hFF;
            3'd4:    return sh & 32'hFFFF;
            default: return word;
        endcase
    endfunction

    task automatic idle_inputs();
        mif.exe_valid         = 1'b0;
        mif.exe_to_mem_bus    = '0;
        mif.exe_excep_bus     = '0;
        mif.exe_tlb_bus       = '0;
        mif.data_sram_data_ok = 1'b0;
        mif.data_sram_rdata   = '0;
        mif.wb_allowin        = 1'b1;
        mif.wb_flush          = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 1'b0;
        #2;
        total_cnt++; if (mif.mem_allowin !== 1'b1) $display("FAIL reset_allowin: got %h expected 1", mif.mem_allowin); else pass_cnt++;
        total_cnt++; if (mif.mem_to_wb_valid !== 1'b0) $display("FAIL reset_to_wb_valid: got %h expected 0", mif.mem_to_wb_valid); else pass_cnt++;
        total_cnt++; if (mif.mem_cancel !== 1'b0) $display("FAIL reset_cancel: got %h expected 0", mif.mem_cancel); else pass_cnt++;
        total_cnt++; if (mif.mem_fwd !== 39'd0) $display("FAIL reset_fwd: got %h expected 0", mif.mem_fwd); else pass_cnt++;
        total_cnt++; if (mif.mem_to_wb_bus !== 70'd0) $display("FAIL reset_wb_bus: got %h expected 0", mif.mem_to_wb_bus); else pass_cnt++;
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_ld_b();
        idle_inputs();
        mif.exe_valid      = 1'b1;
        mif.exe_to_mem_bus = mk_bus(32'h1C00_0010, 1'b1, 5'd3, 32'h0000_1003, 1'b1, 3'b001, 1'b1);
        #1;
        total_cnt++; if (mif.mem_allowin !== 1'b1) $display("FAIL ldb_accept: got %h expected 1", mif.mem_allowin); else pass_cnt++;
        tick();
        mif.exe_valid         = 1'b0;
        mif.data_sram_data_ok = 1'b1;
        mif.data_sram_rdata   = 32'h80FF_0000;
        #1;
        total_cnt++; if (mif.mem_to_wb_valid !== 1'b1) $display("FAIL ldb_valid: got %h expected 1", mif.mem_to_wb_valid); else pass_cnt++;
        total_cnt++; if (mif.mem_to_wb_bus !== {32'h1C00_0010, 1'b1, 5'd3, 32'hFFFF_FF80})
            $display("FAIL ldb_bus: got %h expected %h", mif.mem_to_wb_bus, {32'h1C00_0010, 1'b1, 5'd3, 32'hFFFF_FF80}); else pass_cnt++;
        tick();
        idle_inputs();
        #1;
        total_cnt++; if (mif.mem_to_wb_valid !== 1'b0) $display("FAIL ldb_left: got %h expected 0", mif.mem_to_wb_valid); else pass_cnt++;
        tick();
    endtask

    task automatic test_ld_hu_buffered();
        idle_inputs();
        mif.exe_valid      = 1'b1;
        mif.exe_to_mem_bus = mk_bus(32'h1C00_0020, 1'b1, 5'd4, 32'h0000_2002, 1'b1, 3'b100, 1'b1);
        tick();
        mif.exe_valid         = 1'b0;
        mif.wb_allowin        = 1'b0;
        mif.data_sram_data_ok = 1'b1;
        mif.data_sram_rdata   = 32'hBEEF_1234;
        for (int i = 0; i < 3; i++) begin
            #1;
            total_cnt++; if (mif.mem_to_wb_valid !== 1'b1) $display("FAIL hu_hold_valid[%0d]: got %h expected 1", i, mif.mem_to_wb_valid); else pass_cnt++;
            total_cnt++; if (mif.mem_to_wb_bus[31:0] !== 32'h0000_BEEF) $display("FAIL hu_hold_result[%0d]: got %h expected 0000beef", i, mif.mem_to_wb_bus[31:0]); else pass_cnt++;
            total_cnt++; if (mif.mem_allowin !== 1'b0) $display("FAIL hu_hold_allowin[%0d]: got %h expected 0", i, mif.mem_allowin); else pass_cnt++;
            tick();
            mif.data_sram_data_ok = 1'b0;
            mif.data_sram_rdata   = 32'hDEAD_DEAD;
        end
        mif.wb_allowin = 1'b1;
        #1;
        total_cnt++; if (mif.mem_allowin !== 1'b1) $display("FAIL hu_release_allowin: got %h expected 1", mif.mem_allowin); else pass_cnt++;
        total_cnt++; if (mif.mem_to_wb_bus[31:0] !== 32'h0000_BEEF) $display("FAIL hu_release_result: got %h expected 0000beef", mif.mem_to_wb_bus[31:0]); else pass_cnt++;
        tick();
        #1;
        total_cnt++; if (mif.mem_to_wb_valid !== 1'b0) $display("FAIL hu_left: got %h expected 0", mif.mem_to_wb_valid); else pass_cnt++;
        tick();
    endtask

    task automatic test_wait();
        idle_inputs();
        mif.exe_valid      = 1'b1;
        mif.exe_to_mem_bus = mk_bus(32'h1C00_0030, 1'b1, 5'd6, 32'h0000_3000, 1'b1, 3'b000, 1'b1);
        tick();
        mif.exe_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            total_cnt++; if (mif.mem_allowin !== 1'b0) $display("FAIL wait_allowin[%0d]: got %h expected 0", i, mif.mem_allowin); else pass_cnt++;
            total_cnt++; if (mif.mem_fwd[0] !== 1'b1) $display("FAIL wait_ld_pending[%0d]: got %h expected 1", i, mif.mem_fwd[0]); else pass_cnt++;
            total_cnt++; if (mif.mem_to_wb_valid !== 1'b0) $display("FAIL wait_valid[%0d]: got %h expected 0", i, mif.mem_to_wb_valid); else pass_cnt++;
            tick();
        end
        mif.data_sram_data_ok = 1'b1;
        mif.data_sram_rdata   = 32'h1234_5678;
        #1;
        total_cnt++; if (mif.mem_to_wb_valid !== 1'b1) $display("FAIL wait_done_valid: got %h expected 1", mif.mem_to_wb_valid); else pass_cnt++;
        total_cnt++; if (mif.mem_to_wb_bus[31:0] !== 32'h1234_5678) $display("FAIL wait_done_result: got %h expected 12345678", mif.mem_to_wb_bus[31:0]); else pass_cnt++;
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_flush_discard();
        idle_inputs();
        mif.exe_valid      = 1'b1;
        mif.exe_to_mem_bus = mk_bus(32'h1C00_0040, 1'b1, 5'd7, 32'h0000_4000, 1'b1, 3'b000, 1'b1);
        tick();
        mif.exe_valid = 1'b0;
        mif.wb_flush  = 1'b1;
        #1;
        total_cnt++; if (mif.mem_to_wb_valid !== 1'b0) $display("FAIL fl_valid: got %h expected 0", mif.mem_to_wb_valid); else pass_cnt++;
        tick();
        mif.wb_flush       = 1'b0;
        mif.exe_valid      = 1'b1;
        mif.exe_to_mem_bus = mk_bus(32'h1C00_0044, 1'b1, 5'd8, 32'h0000_55AA, 1'b0, 3'b000, 1'b0);
        #1;
        total_cnt++; if (mif.mem_allowin !== 1'b1) $display("FAIL fl_add_accept: got %h expected 1", mif.mem_allowin); else pass_cnt++;
        tick();
        mif.exe_valid         = 1'b0;
        mif.wb_allowin        = 1'b0;
        mif.data_sram_data_ok = 1'b1;
        mif.data_sram_rdata   = 32'h0000_CAFE;
        #1;
        total_cnt++; if (mif.mem_to_wb_valid !== 1'b1) $display("FAIL fl_add_valid: got %h expected 1", mif.mem_to_wb_valid); else pass_cnt++;
        total_cnt++; if (mif.mem_to_wb_bus[31:0] !== 32'h0000_55AA) $display("FAIL fl_add_result: got %h expected 000055aa", mif.mem_to_wb_bus[31:0]); else pass_cnt++;
        tick();
        mif.data_sram_data_ok = 1'b0;
        mif.wb_allowin        = 1'b1;
        mif.exe_valid         = 1'b1;
        mif.exe_to_mem_bus    = mk_bus(32'h1C00_0048, 1'b1, 5'd9, 32'h0000_4004, 1'b1, 3'b000, 1'b1);
        tick();
        mif.exe_valid         = 1'b0;
        mif.data_sram_data_ok = 1'b1;
        mif.data_sram_rdata   = 32'h1111_2222;
        #1;
        total_cnt++; if (mif.mem_to_wb_valid !== 1'b1) $display("FAIL fl_after_valid: got %h expected 1", mif.mem_to_wb_valid); else pass_cnt++;
        total_cnt++; if (mif.mem_to_wb_bus[31:0] !== 32'h1111_2222) $display("FAIL fl_after_result: got %h expected 11112222", mif.mem_to_wb_bus[31:0]); else pass_cnt++;
        tick();
        // A load accepted straight after a flush must ignore the stale response.
        idle_inputs();
        mif.exe_valid      = 1'b1;
        mif.exe_to_mem_bus = mk_bus(32'h1C00_0050, 1'b1, 5'd10, 32'h0000_5000, 1'b1, 3'b000, 1'b1);
        tick();
        mif.exe_valid = 1'b0;
        mif.wb_flush  = 1'b1;
        tick();
        mif.wb_flush       = 1'b0;
        mif.exe_valid      = 1'b1;
        mif.exe_to_mem_bus = mk_bus(32'h1C00_0054, 1'b1, 5'd11, 32'h0000_5002, 1'b1, 3'b010, 1'b1);
        tick();
        mif.exe_valid         = 1'b0;
        mif.data_sram_data_ok = 1'b1;
        mif.data_sram_rdata   = 32'hBAD0_BAD0;
        #1;
        total_cnt++; if (mif.mem_to_wb_valid !== 1'b0) $display("FAIL stale_valid: got %h expected 0", mif.mem_to_wb_valid); else pass_cnt++;
        total_cnt++; if (mif.mem_fwd[0] !== 1'b1) $display("FAIL stale_ld_pending: got %h expected 1", mif.mem_fwd[0]); else pass_cnt++;
        tick();
        mif.data_sram_rdata = 32'h8001_0000;
        #1;
        total_cnt++; if (mif.mem_to_wb_valid !== 1'b1) $display("FAIL stale_next_valid: got %h expected 1", mif.mem_to_wb_valid); else pass_cnt++;
        total_cnt++; if (mif.mem_to_wb_bus[31:0] !== 32'hFFFF_8001) $display("FAIL stale_next_result: got %h expected ffff8001", mif.mem_to_wb_bus[31:0]); else pass_cnt++;
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_flush_same_cycle();
        idle_inputs();
        mif.exe_valid      = 1'b1;
        mif.exe_to_mem_bus = mk_bus(32'h1C00_0060, 1'b1, 5'd12, 32'h0000_6000, 1'b1, 3'b000, 1'b1);
        tick();
        mif.exe_valid         = 1'b0;
        mif.wb_flush          = 1'b1;
        mif.data_sram_data_ok = 1'b1;
        mif.data_sram_rdata   = 32'h7777_7777;
        #1;
        total_cnt++; if (mif.mem_to_wb_valid !== 1'b0) $display("FAIL same_valid: got %h expected 0", mif.mem_to_wb_valid); else pass_cnt++;
        tick();
        idle_inputs();
        mif.exe_valid      = 1'b1;
        mif.exe_to_mem_bus = mk_bus(32'h1C00_0064, 1'b1, 5'd13, 32'h0000_5001, 1'b1, 3'b011, 1'b1);
        tick();
        mif.exe_valid         = 1'b0;
        mif.data_sram_data_ok = 1'b1;
        mif.data_sram_rdata   = 32'h0000_AB00;
        #1;
        total_cnt++; if (mif.mem_to_wb_valid !== 1'b1) $display("FAIL same_next_valid: got %h expected 1", mif.mem_to_wb_valid); else pass_cnt++;
        total_cnt++; if (mif.mem_to_wb_bus[31:0] !== 32'h0000_00AB) $display("FAIL same_next_result: got %h expected 000000ab", mif.mem_to_wb_bus[31:0]); else pass_cnt++;
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_async_reset();
        idle_inputs();
        mif.exe_valid      = 1'b1;
        mif.exe_to_mem_bus = mk_bus(32'h1C00_0070, 1'b1, 5'd14, 32'h0000_7000, 1'b1, 3'b000, 1'b1);
        tick();
        mif.exe_valid = 1'b0;
        #1;
        total_cnt++; if (mif.mem_allowin !== 1'b0) $display("FAIL arst_pre_allowin: got %h expected 0", mif.mem_allowin); else pass_cnt++;
        #1;
        resetn = 1'b0;
        #1;
        total_cnt++; if (mif.mem_allowin !== 1'b1) $display("FAIL arst_allowin: got %h expected 1", mif.mem_allowin); else pass_cnt++;
        total_cnt++; if (mif.mem_fwd !== 39'd0) $display("FAIL arst_fwd: got %h expected 0", mif.mem_fwd); else pass_cnt++;
        total_cnt++; if (mif.mem_to_wb_valid !== 1'b0) $display("FAIL arst_valid: got %h expected 0", mif.mem_to_wb_valid); else pass_cnt++;
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_fwd();
        idle_inputs();
        mif.exe_valid      = 1'b1;
        mif.exe_to_mem_bus = mk_bus(32'h1C00_0080, 1'b1, 5'd5, 32'h0000_1234, 1'b0, 3'b000, 1'b0);
        tick();
        mif.exe_valid  = 1'b0;
        mif.wb_allowin = 1'b0;
        #1;
        total_cnt++; if (mif.mem_fwd !== {1'b1, 5'd5, 32'h0000_1234, 1'b0})
            $display("FAIL fwd_value: got %h expected %h", mif.mem_fwd, {1'b1, 5'd5, 32'h0000_1234, 1'b0}); else pass_cnt++;
        total_cnt++; if (mif.mem_to_wb_valid !== 1'b1) $display("FAIL fwd_readygo: got %h expected 1", mif.mem_to_wb_valid); else pass_cnt++;
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_cancel();
        logic [EXC_W-1:0] e;
        logic [TLB_W-1:0] t;
        for (int k = 0; k < 4; k++) begin
            idle_inputs();
            e = rand_exc();
            e[1:0] = 2'(k);
            t = TLB_W'($urandom);
            mif.exe_valid      = 1'b1;
            mif.exe_to_mem_bus = mk_bus(32'h1C00_0090, 1'b0, 5'd0, 32'h0000_0090, 1'b0, 3'b000, 1'b0);
            mif.exe_excep_bus  = e;
            mif.exe_tlb_bus    = t;
            tick();
            mif.exe_valid  = 1'b0;
            mif.wb_allowin = 1'b0;
            #1;
            total_cnt++; if (mif.mem_cancel !== (k != 0)) $display("FAIL cancel[%0d]: got %h expected %h", k, mif.mem_cancel, (k != 0)); else pass_cnt++;
            total_cnt++; if (mif.mem_to_wb_excep !== e) $display("FAIL excep_pass[%0d]: got %h expected %h", k, mif.mem_to_wb_excep, e); else pass_cnt++;
            total_cnt++; if (mif.mem_to_wb_tlb !== t) $display("FAIL tlb_pass[%0d]: got %h expected %h", k, mif.mem_to_wb_tlb, t); else pass_cnt++;
            tick();
            idle_inputs();
            tick();
        end
    endtask

    task automatic test_random();
        instr_t           cur, nxt;
        logic [EXC_W-1:0] m_exc, n_exc;
        logic [TLB_W-1:0] m_tlb, n_tlb;
        logic             m_valid, m_have, outstanding, flush, dok, allow, resp_mine, ready, leaving;
        logic [31:0]      m_data, word, res;
        int               stale;
        do_reset();
        cur = '{pc: '0, we: 1'b0, waddr: '0, alu: '0, rfm: 1'b0, ldt: '0, rs: 1'b0};
        m_exc = '0; m_tlb = '0; m_valid = 1'b0; m_have = 1'b0; m_data = '0; stale = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            outstanding = m_valid && cur.rs && !m_have;
            flush = (stale == 0) && ($urandom_range(0, 11) == 0);
            dok   = (stale > 0 || outstanding) && ($urandom_range(0, 2) == 0);
            nxt.pc    = $urandom;
            nxt.we    = 1'($urandom);
            nxt.waddr = 5'($urandom);
            nxt.alu   = $urandom;
            nxt.rfm   = 1'($urandom);
            nxt.ldt   = 3'($urandom);
            nxt.rs    = nxt.rfm && ($urandom_range(0, 3) != 0);
            n_exc = rand_exc();
            n_exc[1:0] = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
            n_tlb = TLB_W'($urandom);
            mif.exe_valid         = ($urandom_range(0, 4) < 3);
            mif.exe_to_mem_bus    = mk_bus(nxt.pc, nxt.we, nxt.waddr, nxt.alu, nxt.rfm, nxt.ldt, nxt.rs);
            mif.exe_excep_bus     = n_exc;
            mif.exe_tlb_bus       = n_tlb;
            mif.data_sram_data_ok = dok;
            mif.data_sram_rdata   = $urandom;
            mif.wb_allowin        = ($urandom_range(0, 9) < 7);
            mif.wb_flush          = flush;
            #1;
            resp_mine = dok && (stale == 0);
            ready     = !cur.rs || m_have || resp_mine;
            allow     = !m_valid || (ready && mif.wb_allowin);
            word      = m_have ? m_data : mif.data_sram_rdata;
            res       = cur.rfm ? ref_load(word, cur.alu[1:0], cur.ldt) : cur.alu;
            total_cnt++; if (mif.mem_allowin !== allow) $display("FAIL rnd_allowin@%0d: got %h expected %h", cyc, mif.mem_allowin, allow); else pass_cnt++;
            total_cnt++; if (mif.mem_to_wb_valid !== (m_valid && ready && !flush))
                $display("FAIL rnd_valid@%0d: got %h expected %h", cyc, mif.mem_to_wb_valid, (m_valid && ready && !flush)); else pass_cnt++;
            total_cnt++; if (mif.mem_to_wb_bus !== {cur.pc, cur.we, cur.waddr, res})
                $display("FAIL rnd_bus@%0d: got %h expected %h", cyc, mif.mem_to_wb_bus, {cur.pc, cur.we, cur.waddr, res}); else pass_cnt++;
            total_cnt++; if (mif.mem_fwd !== {m_valid && cur.we, cur.waddr, res, m_valid && cur.rfm && !ready})
                $display("FAIL rnd_fwd@%0d: got %h expected %h", cyc, mif.mem_fwd, {m_valid && cur.we, cur.waddr, res, m_valid && cur.rfm && !ready}); else pass_cnt++;
            total_cnt++; if (mif.mem_cancel !== (m_valid && (m_exc[0] || m_exc[1])))
                $display("FAIL rnd_cancel@%0d: got %h expected %h", cyc, mif.mem_cancel, (m_valid && (m_exc[0] || m_exc[1]))); else pass_cnt++;
            total_cnt++; if ({mif.mem_to_wb_excep, mif.mem_to_wb_tlb} !== {m_exc, m_tlb})
                $display("FAIL rnd_passthru@%0d: got %h expected %h", cyc, {mif.mem_to_wb_excep, mif.mem_to_wb_tlb}, {m_exc, m_tlb}); else pass_cnt++;
            leaving = m_valid && ready && mif.wb_allowin;
            if (dok && stale > 0) stale--;
            if (flush && outstanding && !dok) stale++;
            if (flush || leaving) m_have = 1'b0;
            else if (m_valid && resp_mine && !m_have) begin
                m_have = 1'b1;
                m_data = mif.data_sram_rdata;
            end
            if (mif.exe_valid && allow) begin
                cur = nxt; m_exc = n_exc; m_tlb = n_tlb;
            end
            m_valid = flush ? 1'b0 : (allow ? mif.exe_valid : m_valid);
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        resetn = 1'b1;
        idle_inputs();
        #1;
        test_reset();
        test_ld_b();
        test_ld_hu_buffered();
        test_wait();
        test_flush_discard();
        test_flush_same_cycle();
        test_async_reset();
        test_fwd();
        test_cancel();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
